// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: parity modes, FSM states and the
// bit-period divider calculation.
// The BRK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
`ifdef UART_TX_BREAK_EN
      , BRK = 3'd5
`endif
   } tx_state_e;

   // Clock cycles per bit, rounded to nearest.
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_baud_strobe.sv
// Bit-period strobe generator: one-cycle pulse every DIV cycles while en=1.
// The counter is cleared whenever en=0, so the first strobe after enabling
// arrives exactly DIV cycles later.
module uart_baud_strobe #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic strobe
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_reg;

   assign strobe = en && (cnt_reg == CW'(DIV - 1));

   // Count 0..DIV-1 while enabled, hold at zero otherwise.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_reg <= '0;
      end else if (cnt_reg == CW'(DIV - 1)) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable frame (data bits, parity, stop bits)
// and a valid/ready input. All outputs except in_ready are plain registers.
// Optional macro UART_TX_BREAK_EN adds the break_req input and BRK state.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int      CLK_HZ    = 100_000_000,
   parameter int      BAUD      = 115200,
   parameter int      DATA_BITS = 8,
   parameter parity_e PARITY    = PAR_NONE,
   parameter int      STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
`ifdef UART_TX_BREAK_EN
   input  logic                 break_req,
`endif
   output logic                 in_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_frame: bit period DIV=%0d is below 2", DIV);
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS=%0d outside 5..9", DATA_BITS);
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
   end

   tx_state_e            state_reg, state_next;
   logic                 tx_reg, tx_next;
   logic                 ready_reg, ready_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [3:0]           bit_cnt_reg, bit_cnt_next;
   logic                 stop_cnt_reg, stop_cnt_next;
   logic                 parity_reg, parity_next;
   logic                 strobe;
   logic                 transfer;

`ifdef UART_TX_BREAK_EN
   logic                 brk_hold_reg, brk_hold_next;
   // A pending break wins over data, so never advertise ready alongside it.
   assign in_ready = ready_reg & ~break_req;
`else
   assign in_ready = ready_reg;
`endif

   assign transfer   = in_valid && in_ready;
   assign tx         = tx_reg;
   assign busy       = busy_reg;
   assign frame_done = done_reg;

   uart_baud_strobe #(
      .DIV (DIV)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .en     (state_reg != IDLE),
      .strobe (strobe)
   );

   // Next-state and output logic for the frame sequencer.
   always_comb begin
      state_next    = state_reg;
      tx_next       = tx_reg;
      ready_next    = ready_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      stop_cnt_next = stop_cnt_reg;
      parity_next   = parity_reg;
`ifdef UART_TX_BREAK_EN
      brk_hold_next = brk_hold_reg;
`endif
      case (state_reg)
         IDLE: begin
            tx_next    = 1'b1;
            ready_next = 1'b1;
            busy_next  = 1'b0;
`ifdef UART_TX_BREAK_EN
            if (break_req) begin
               state_next    = BRK;
               tx_next       = 1'b0;
               ready_next    = 1'b0;
               busy_next     = 1'b1;
               brk_hold_next = 1'b0;
            end else
`endif
            if (transfer) begin
               state_next  = START;
               tx_next     = 1'b0;
               ready_next  = 1'b0;
               busy_next   = 1'b1;
               shift_next  = in_data;
               parity_next = (^in_data) ^ (PARITY == PAR_ODD);
            end
         end
         START: begin
            if (strobe) begin
               state_next   = DATA;
               tx_next      = shift_reg[0];
               shift_next   = shift_reg >> 1;
               bit_cnt_next = '0;
            end
         end
         DATA: begin
            if (strobe) begin
               if (bit_cnt_reg == 4'(DATA_BITS - 1)) begin
                  if (PARITY != PAR_NONE) begin
                     state_next = PAR;
                     tx_next    = parity_reg;
                  end else begin
                     state_next    = STOP;
                     tx_next       = 1'b1;
                     stop_cnt_next = 1'b0;
                  end
               end else begin
                  tx_next      = shift_reg[0];
                  shift_next   = shift_reg >> 1;
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end
            end
         end
         PAR: begin
            if (strobe) begin
               state_next    = STOP;
               tx_next       = 1'b1;
               stop_cnt_next = 1'b0;
            end
         end
         STOP: begin
            if (strobe) begin
               if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
                  state_next = IDLE;
                  ready_next = 1'b1;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
               end else begin
                  stop_cnt_next = 1'b1;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         BRK: begin
            // Low while break is requested, then one high bit period.
            tx_next = brk_hold_reg;
            if (strobe) begin
               if (brk_hold_reg) begin
                  state_next = IDLE;
                  ready_next = 1'b1;
                  busy_next  = 1'b0;
               end else if (!break_req) begin
                  brk_hold_next = 1'b1;
                  tx_next       = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         tx_reg       <= 1'b1;
         ready_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         parity_reg   <= 1'b0;
`ifdef UART_TX_BREAK_EN
         brk_hold_reg <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         tx_reg       <= tx_next;
         ready_reg    <= ready_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         shift_reg    <= shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop_cnt_reg <= stop_cnt_next;
         parity_reg   <= parity_next;
`ifdef UART_TX_BREAK_EN
         brk_hold_reg <= brk_hold_next;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four instances at DIV=10 (8N1, 8E1, 8O1, 7N2).
// Expected line bits are queued when a word is offered and popped at each
// mid-bit sample. The break test runs when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data    [4];
   logic       in_valid   [4];
   logic       in_ready   [4];
   logic       tx         [4];
   logic       busy       [4];
   logic       frame_done [4];
`ifdef UART_TX_BREAK_EN
   logic       break_req  [4];
`endif

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int      DB = (gi == 3) ? 7 : 8;
      localparam int      SB = (gi == 3) ? 2 : 1;
      localparam parity_e PM = parity_e'((gi == 1) ? 1 : (gi == 2) ? 2 : 0);

      uart_tx_frame #(
         .CLK_HZ    (10_000_000),
         .BAUD      (1_000_000),
         .DATA_BITS (DB),
         .PARITY    (PM),
         .STOP_BITS (SB)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .in_data    (in_data[gi][DB-1:0]),
         .in_valid   (in_valid[gi]),
`ifdef UART_TX_BREAK_EN
         .break_req  (break_req[gi]),
`endif
         .in_ready   (in_ready[gi]),
         .tx         (tx[gi]),
         .busy       (busy[gi]),
         .frame_done (frame_done[gi])
      );
   end

   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic chkn(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Queue the line bits instance k must produce for word w.
   task automatic push_frame(input int k, input logic [7:0] w);
      int nb;
      nb = (k == 3) ? 7 : 8;
      exp_q.push_back(1'b0);
      for (int i = 0; i < nb; i++) exp_q.push_back(w[i]);
      if (k == 1) exp_q.push_back(^w);
      if (k == 2) exp_q.push_back(~(^w));
      exp_q.push_back(1'b1);
      if (k == 3) exp_q.push_back(1'b1);
   endtask

   // Offer word w at the current negedge; returns at the negedge after accept.
   task automatic start_frame(input int k, input logic [7:0] w, input bit keep);
      chk1("ready_before_accept", in_ready[k], 1'b1);
      in_data[k]  = w;
      in_valid[k] = 1'b1;
      push_frame(k, w);
      @(negedge clk);
      if (!keep) in_valid[k] = 1'b0;
      in_data[k] = ~w;
      chk1("done_low_after_accept", frame_done[k], 1'b0);
   endtask

   // Follow one frame; optionally pulse in_valid mid-frame with junk data.
   task automatic watch_frame(input int k, input logic [7:0] w, input int exp_len,
                              input bit poke);
      int   cyc;
      int   done_cnt;
      logic b;
      cyc      = 0;
      done_cnt = 0;
      chk1("start_latency_tx", tx[k], 1'b0);
      chk1("busy_in_frame", busy[k], 1'b1);
      while (in_ready[k] !== 1'b1 && cyc < 400) begin
         if (frame_done[k] === 1'b1) done_cnt++;
         if (cyc % 10 == 5) begin
            chkn("queue_has_bit", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               b = exp_q.pop_front();
               chk1("line_bit", tx[k], b);
            end
         end
         if (poke && cyc == 30) begin
            in_valid[k] = 1'b1;
            in_data[k]  = 8'($urandom_range(0, 255));
         end
         if (poke && cyc == 33) in_valid[k] = 1'b0;
         cyc++;
         @(negedge clk);
      end
      if (frame_done[k] === 1'b1) done_cnt++;
      chkn("frame_length", cyc, exp_len);
      chkn("frame_done_count", done_cnt, 1);
      chkn("queue_empty", exp_q.size(), 0);
      chk1("busy_after_frame", busy[k], 1'b0);
      chk1("tx_after_frame", tx[k], 1'b1);
      $display("frame inst=%0d word=%02h cycles=%0d done=%0d", k, w, cyc, done_cnt);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid[i] = 1'b0;
         in_data[i]  = 8'h00;
`ifdef UART_TX_BREAK_EN
         break_req[i] = 1'b0;
`endif
      end
      repeat (3) @(negedge clk);
      chk1("reset_tx", tx[0], 1'b1);
      chk1("reset_ready", in_ready[0], 1'b0);
      chk1("reset_busy", busy[0], 1'b0);
      chk1("reset_done", frame_done[0], 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk1("ready_after_reset", in_ready[0], 1'b1);
      $display("reset released, ready=%b", in_ready[0]);

      // Idle line with no valid.
      for (int i = 0; i < 15; i++) begin
         chk1("idle_tx", tx[0], 1'b1);
         chk1("idle_busy", busy[0], 1'b0);
         @(negedge clk);
      end
      $display("idle hold 15 cycles");

      // 8N1, then 8E1 and 8O1 with the same word.
      start_frame(0, 8'h3C, 1'b0);
      watch_frame(0, 8'h3C, 100, 1'b0);
      start_frame(1, 8'h3C, 1'b0);
      watch_frame(1, 8'h3C, 110, 1'b0);
      start_frame(2, 8'h3C, 1'b0);
      watch_frame(2, 8'h3C, 110, 1'b0);
      start_frame(2, 8'hB7, 1'b0);
      watch_frame(2, 8'hB7, 110, 1'b0);

      // in_valid pulses mid-frame must not disturb the word on the line.
      start_frame(0, 8'hC3, 1'b0);
      watch_frame(0, 8'hC3, 100, 1'b1);
      chk1("no_accept_after_poke", busy[0], 1'b0);

      // 7N2 back-to-back with in_valid held high.
      start_frame(3, 8'h55, 1'b1);
      watch_frame(3, 8'h55, 100, 1'b0);
      start_frame(3, 8'h2A, 1'b0);
      watch_frame(3, 8'h2A, 100, 1'b0);

      // Reset 35 cycles into a frame (line is low there for 0x5A).
      start_frame(0, 8'h5A, 1'b0);
      repeat (35) @(negedge clk);
      chk1("tx_before_midreset", tx[0], 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk1("midreset_tx", tx[0], 1'b1);
      chk1("midreset_ready", in_ready[0], 1'b0);
      chk1("midreset_busy", busy[0], 1'b0);
      chk1("midreset_done", frame_done[0], 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk1("ready_after_midreset", in_ready[0], 1'b1);
      chk1("no_done_after_midreset", frame_done[0], 1'b0);
      $display("mid-frame reset, ready=%b done=%b", in_ready[0], frame_done[0]);
      exp_q.delete();
      start_frame(0, 8'h96, 1'b0);
      watch_frame(0, 8'h96, 100, 1'b0);

`ifdef UART_TX_BREAK_EN
      begin
         int lo;
         int hi;
         int cyc;
         lo  = 0;
         hi  = 0;
         cyc = 0;
         break_req[0] = 1'b1;
         in_data[0]   = 8'h11;
         in_valid[0]  = 1'b1;
         chk1("ready_masked_by_break", in_ready[0], 1'b0);
         @(negedge clk);
         chk1("break_busy", busy[0], 1'b1);
         while (in_ready[0] !== 1'b1 && cyc < 200) begin
            if (cyc == 34) break_req[0] = 1'b0;
            if (tx[0] === 1'b0) lo++;
            else hi++;
            cyc++;
            @(negedge clk);
         end
         chkn("break_low_cycles", lo, 40);
         chkn("break_high_cycles", hi, 10);
         chkn("break_total_cycles", cyc, 50);
         $display("break low=%0d high=%0d", lo, hi);
         push_frame(0, 8'h11);
         @(negedge clk);
         in_valid[0] = 1'b0;
         in_data[0]  = 8'hEE;
         watch_frame(0, 8'h11, 100, 1'b0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
